// File: rtl/adj_button_conditioner.sv
// ---------------------------------------------------------------------------
// adj_button_conditioner
//
// Turns the three raw clock-adjust push-buttons (hours / minutes / seconds)
// into clean single-cycle adjust pulses for the VGA clock core. It runs on the
// pixel clock. Each channel has these stages:
//   raw -> 2-FF synchroniser -> counter debouncer -> press FSM
// The press FSM emits one pulse per press. While the button stays held, it
// optionally emits auto-repeat pulses.
//
// Ports
//   clk        pixel clock, sole clock
//   reset_n    asynchronous, active-low reset
//   btn_hrs    raw hours button (active-high, asynchronous, may bounce)
//   btn_min    raw minutes button
//   btn_sec    raw seconds button
//   adj_hrs    one-cycle hours adjust pulse (registered)
//   adj_min    one-cycle minutes adjust pulse (registered)
//   adj_sec    one-cycle seconds adjust pulse (registered)
//   btn_state  debounced levels {hrs, min, sec} (registered)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adj_button_channel
//
// One fully independent button channel.
//
// Ports
//   clk    pixel clock
//   rst_n  asynchronous, active-low reset
//   raw    raw button level
//   pulse  registered one-cycle adjust pulse
//   level  registered debounced level
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | button released (debounced); waiting for a press
// DELAY   | pressed and pulsed; counting towards the first repeat
// REPEAT  | auto-repeating; one pulse every REPEAT_PERIOD_CYCLES
// HELD    | pressed with auto-repeat disabled; waits silently for release
// ---------------------------------------------------------------------------
module adj_button_channel #(
    parameter int DEBOUNCE_CYCLES      = 315000,
    parameter int REPEAT_DELAY_CYCLES  = 15750000,
    parameter int REPEAT_PERIOD_CYCLES = 6300000,
    parameter int ENABLE_REPEAT        = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES)
                              ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } state_t;

    logic              s1;
    logic              s2;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    logic              db_done;
    logic              rise;
    logic              fall;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              pulse_nxt;

    // Two-flop synchroniser; only s2 is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the accepted level clears the count, so a
    // glitch shorter than DEBOUNCE_CYCLES earns no partial credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // The FSM acts on the same edge at which the debounced level changes.
    // This lets the press pulse register alongside the new level rather than
    // one cycle behind it.
    assign db_done = (s2 != stable) && (db_cnt == DB_LAST);
    assign rise    = db_done &  s2;
    assign fall    = db_done & ~s2;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pulse_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    pulse_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = (ENABLE_REPEAT != 0) ? ST_DELAY : ST_HELD;
                end
            end
            ST_DELAY: begin
                // Release takes priority over a coincident repeat.
                if (fall) begin
                    hold_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (hold_cnt == DELAY_LAST) begin
                    pulse_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = ST_REPEAT;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    hold_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (hold_cnt == PERIOD_LAST) begin
                    pulse_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    hold_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                hold_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pulse is a flop with async clear, so a reset truncates it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            pulse    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            pulse    <= pulse_nxt;
        end
    end

    assign level = stable;

endmodule

module adj_button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 315000,
    parameter int REPEAT_DELAY_CYCLES  = 15750000,
    parameter int REPEAT_PERIOD_CYCLES = 6300000,
    parameter int ENABLE_REPEAT        = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_hrs,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic       adj_hrs,
    output logic       adj_min,
    output logic       adj_sec,
    output logic [2:0] btn_state
);

    logic level_hrs;
    logic level_min;
    logic level_sec;

    adj_button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
        .ENABLE_REPEAT       (ENABLE_REPEAT)
    ) u_hrs (
        .clk  (clk),
        .rst_n(reset_n),
        .raw  (btn_hrs),
        .pulse(adj_hrs),
        .level(level_hrs)
    );

    adj_button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
        .ENABLE_REPEAT       (ENABLE_REPEAT)
    ) u_min (
        .clk  (clk),
        .rst_n(reset_n),
        .raw  (btn_min),
        .pulse(adj_min),
        .level(level_min)
    );

    adj_button_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
        .ENABLE_REPEAT       (ENABLE_REPEAT)
    ) u_sec (
        .clk  (clk),
        .rst_n(reset_n),
        .raw  (btn_sec),
        .pulse(adj_sec),
        .level(level_sec)
    );

    // Each level is a flop output inside its channel, so this bus is registered.
    assign btn_state = {level_hrs, level_min, level_sec};

endmodule

// File: tb/tb_adj_button_conditioner.sv
module tb_adj_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int NV = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_hrs = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_sec_nr = 1'b0;
    logic       adj_hrs, adj_min, adj_sec;
    logic [2:0] btn_state;
    logic       nr_hrs, nr_min, nr_sec;
    logic [2:0] nr_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base;

    typedef struct {
        int ch;
        int edge_no;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] btn;
        int         hold;
        logic [2:0] state_held;
        int         n_pulse;
        int         pulse_at[6];
    } vec_t;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    adj_button_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_PERIOD_CYCLES(RP), .ENABLE_REPEAT(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_hrs(btn_hrs), .btn_min(btn_min), .btn_sec(btn_sec),
        .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
        .btn_state(btn_state)
    );

    adj_button_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_PERIOD_CYCLES(RP), .ENABLE_REPEAT(0)
    ) dut_nr (
        .clk(clk), .reset_n(reset_n),
        .btn_hrs(1'b0), .btn_min(1'b0), .btn_sec(btn_sec_nr),
        .adj_hrs(nr_hrs), .adj_min(nr_min), .adj_sec(nr_sec),
        .btn_state(nr_state)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int ch, input int edge_no);
        exp_t e;
        e.ch = ch;
        e.edge_no = edge_no;
        sb.push_back(e);
    endtask

    task automatic drained(input string nm);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing_pulses actual=%0d required=0 (next ch=%0d edge=%0d)",
                     nm, sb.size(), sb[0].ch, sb[0].edge_no);
            sb.delete();
        end
    endtask

    task automatic set_vec(input int i, input logic [2:0] b, input int h, input logic [2:0] s,
                           input int n, input int p0, input int p1, input int p2,
                           input int p3, input int p4);
        vecs[i].btn = b;
        vecs[i].hold = h;
        vecs[i].state_held = s;
        vecs[i].n_pulse = n;
        vecs[i].pulse_at[0] = p0;
        vecs[i].pulse_at[1] = p1;
        vecs[i].pulse_at[2] = p2;
        vecs[i].pulse_at[3] = p3;
        vecs[i].pulse_at[4] = p4;
        vecs[i].pulse_at[5] = 0;
    endtask

    // Pulse monitor: every high output cycle must match the head of the scoreboard.
    // Channels: 0 hrs, 1 min, 2 sec, 3 no-repeat sec, 4/5 no-repeat hrs/min (must stay 0).
    initial begin
        logic [5:0] pv;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            pv = {nr_min, nr_hrs, nr_sec, adj_sec, adj_min, adj_hrs};
            for (int c = 0; c < 6; c++) begin
                if (pv[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse ch=%0d actual_edge=%0d required=none", c, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (e.ch != c || e.edge_no != cyc) begin
                            failures++;
                            $display("FAIL pulse actual ch=%0d edge=%0d required ch=%0d edge=%0d",
                                     c, cyc, e.ch, e.edge_no);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Edge numbers are relative to the first edge sampling the new level.
        set_vec(0, 3'b100, 30, 3'b100, 5, 5, 15, 20, 25, 30); // repeat at 35 loses to release
        set_vec(1, 3'b010,  2, 3'b000, 0, 0,  0,  0,  0,  0); // short blip
        set_vec(2, 3'b001,  3, 3'b000, 0, 0,  0,  0,  0,  0); // one short of debounce
        set_vec(3, 3'b001,  4, 3'b001, 1, 5,  0,  0,  0,  0); // exactly debounce length
        set_vec(4, 3'b110,  9, 3'b110, 1, 5,  0,  0,  0,  0); // simultaneous, released before repeat
        set_vec(5, 3'b100, 15, 3'b100, 2, 5, 15,  0,  0,  0); // release coincides with repeat at 20

        // Reset state, with a button asserted during reset.
        btn_hrs = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_adj", {adj_hrs, adj_min, adj_sec}, 0);
        check("reset_state", btn_state, 0);
        check("reset_nr", {nr_hrs, nr_min, nr_sec, nr_state}, 0);
        btn_hrs = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_state", btn_state, 0);

        // Table-driven vectors.
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            {btn_hrs, btn_min, btn_sec} = vecs[v].btn;
            base = cyc + 1;
            for (int p = 0; p < vecs[v].n_pulse; p++)
                for (int c = 0; c < 3; c++)
                    if (vecs[v].btn[2-c]) expect_pulse(c, base + vecs[v].pulse_at[p]);
            repeat (vecs[v].hold) @(negedge clk);
            {btn_hrs, btn_min, btn_sec} = 3'b000;
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_state_before_fall", v), btn_state, vecs[v].state_held);
            @(negedge clk);
            check($sformatf("vec%0d_state_after_fall", v), btn_state, 0);
            repeat (20) @(negedge clk);
            drained($sformatf("vec%0d", v));
        end

        // Seconds button bouncing with period 6 for 24 cycles, then held.
        @(negedge clk);
        base = cyc + 1;
        for (int i = 0; i < 24; i++) begin
            btn_sec = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        check("bounce_state", btn_state, 0);
        btn_sec = 1'b1;
        expect_pulse(2, base + 24 + 5);
        repeat (8) @(negedge clk);
        btn_sec = 1'b0;
        repeat (25) @(negedge clk);
        check("bounce_release_state", btn_state, 0);
        drained("bounce");

        // Reset during DELAY while hrs is held, then released with hrs still high.
        @(negedge clk);
        btn_hrs = 1'b1;
        base = cyc + 1;
        expect_pulse(0, base + 5);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_state", btn_state, 0);
        check("midreset_adj", {adj_hrs, adj_min, adj_sec}, 0);
        @(negedge clk);
        @(negedge clk);
        check("midreset_state2", btn_state, 0);
        reset_n = 1'b1;
        base = cyc + 1;
        expect_pulse(0, base + 5);
        repeat (5) @(negedge clk);
        check("rerelease_state_pre", btn_state, 0);
        @(negedge clk);
        check("rerelease_state_post", btn_state, 3'b100);
        repeat (2) @(negedge clk);
        btn_hrs = 1'b0;
        repeat (25) @(negedge clk);
        drained("reset_hold");

        // Reset asserted while a pulse is high truncates it.
        @(negedge clk);
        btn_sec = 1'b1;
        base = cyc + 1;
        expect_pulse(2, base + 5);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        check("trunc_pulse_high", adj_sec, 1);
        reset_n = 1'b0;
        #1;
        check("trunc_pulse_cleared", adj_sec, 0);
        @(negedge clk);
        btn_sec = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        drained("truncate");

        // Auto-repeat disabled: one pulse for a 40-cycle hold.
        @(negedge clk);
        btn_sec_nr = 1'b1;
        base = cyc + 1;
        expect_pulse(3, base + 5);
        repeat (20) @(negedge clk);
        check("norepeat_state", nr_state, 3'b001);
        repeat (20) @(negedge clk);
        btn_sec_nr = 1'b0;
        repeat (25) @(negedge clk);
        check("norepeat_release_state", nr_state, 0);
        drained("norepeat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
